// File: rtl/signed_extreme_tracker_pkg.sv
// signed_extreme_tracker_pkg
// Shared definitions for the signed extreme tracker and its comparator.
//   state_t  : controller states. ACC accepts samples, DONE holds a result.
//   MODE_MAX : the frame tracks its largest sample.
//   MODE_MIN : the frame tracks its smallest sample.
package signed_extreme_tracker_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/signed_better_cmp.sv
// signed_better_cmp
// Purely combinational check of whether a candidate sample should replace the
// current best sample. Both operands are two's-complement signed values.
// Ports:
//   cand   : candidate sample (WIDTH bits, signed)
//   best   : current best sample (WIDTH bits, signed)
//   mode   : MODE_MAX looks for a larger value, MODE_MIN for a smaller one
//   better : 1 when cand is strictly better than best, so ties report 0
module signed_better_cmp
    import signed_extreme_tracker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cand,
    input  logic [WIDTH-1:0] best,
    input  logic             mode,
    output logic             better
);

    logic sign_differs;
    logic cand_greater;
    logic cand_less;

    // When the signs differ, the sign bit decides the order: a negative value
    // always ranks below a non-negative one. When the signs match, the
    // remaining bits order the two values as plain unsigned numbers. Both
    // cases hold for negatives, because a larger low-order field means a value
    // closer to zero. No operand is extended, so no overflow can occur.
    always_comb begin
        sign_differs = cand[WIDTH-1] ^ best[WIDTH-1];
        if (sign_differs) begin
            cand_greater = ~cand[WIDTH-1];
            cand_less    = cand[WIDTH-1];
        end else begin
            cand_greater = cand[WIDTH-2:0] > best[WIDTH-2:0];
            cand_less    = cand[WIDTH-2:0] < best[WIDTH-2:0];
        end
        better = (mode == MODE_MIN) ? cand_less : cand_greater;
    end

endmodule

// File: rtl/signed_extreme_tracker.sv
// signed_extreme_tracker
// Accepts one frame of N_SAMPLES signed samples through a valid/ready
// handshake. It tracks either the largest or the smallest sample; the mode
// seen with the first sample chooses which. The block then holds the extreme
// value and its index within the frame until the sink accepts them.
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   clear                : synchronous abort; discards the current frame or result
//   mode                 : 0 = maximum, 1 = minimum; sampled on the first sample
//   in_valid/in_ready    : sample handshake; in_data holds the signed sample
//   out_valid/out_ready  : result handshake
//   out_data, out_index  : extreme value and its 0-based position in the frame
//   out_mode             : mode that was used for the reported frame
module signed_extreme_tracker
    import signed_extreme_tracker_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int N_SAMPLES = 8,
    localparam int IDX_W     = $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_mode
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] count;
    logic [WIDTH-1:0] best;
    logic [IDX_W-1:0] best_idx;
    logic             frame_mode;
    logic             cand_better;
    logic             take;
    logic             first_sample;
    logic             last_sample;
    logic [WIDTH-1:0] final_data;
    logic [IDX_W-1:0] final_idx;

    signed_better_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .cand   (in_data),
        .best   (best),
        .mode   (frame_mode),
        .better (cand_better)
    );

    // A sample transfers only while the block is accepting and no clear is
    // active. A sample offered in the same cycle as a clear is dropped.
    // The final result merges the last sample into the running best value.
    // It is written straight into the output registers. This means out_data
    // never shows a half-built frame.
    always_comb begin
        take         = in_valid && (state == ACC) && !clear;
        first_sample = (count == '0);
        last_sample  = (count == LAST_IDX);
        final_data   = cand_better ? in_data : best;
        final_idx    = cand_better ? count : best_idx;
    end

    // Holds the controller state. The reset path discards the frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    // Computes the next state and the handshake outputs. A clear wins over
    // both a pending result and a sample that would complete the frame.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (take && last_sample) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ACC;
                end
            end
            default: next_state = ACC;
        endcase
        if (clear) begin
            next_state = ACC;
        end
    end

    // Updates the sample counter, the running best value and index, and the
    // registered result. The first sample loads the best value and latches
    // the mode. Later samples replace the best only when they are strictly
    // better, so on a tie the earlier index stays. The output registers
    // change only when a frame completes, so they keep the previous result
    // while the next frame is gathered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            best       <= '0;
            best_idx   <= '0;
            frame_mode <= MODE_MAX;
            out_data   <= '0;
            out_index  <= '0;
            out_mode   <= MODE_MAX;
        end else if (clear) begin
            count <= '0;
        end else if (take) begin
            if (first_sample) begin
                best       <= in_data;
                best_idx   <= '0;
                frame_mode <= mode;
            end else if (cand_better) begin
                best     <= in_data;
                best_idx <= count;
            end
            if (last_sample) begin
                count     <= '0;
                out_data  <= final_data;
                out_index <= final_idx;
                out_mode  <= frame_mode;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_signed_extreme_tracker.sv
// tb_signed_extreme_tracker
// Self-checking bench for signed_extreme_tracker with WIDTH=3 and N_SAMPLES=4.
// It applies a table of hand-derived frames and then hand-written sequences
// for backpressure, clear and reset. It ends with random frames that it
// checks against a plain integer model of the extreme value.
module tb_signed_extreme_tracker;

    localparam int WIDTH     = 3;
    localparam int N_SAMPLES = 4;
    localparam int IDX_W     = 2;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             mode;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_mode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string                 name;
        logic [3:0][WIDTH-1:0] samples;
        logic [3:0]            modes;
        int                    exp_data;
        int                    exp_idx;
        int                    exp_mode;
        int                    hold;
    } vec_t;

    vec_t vectors[7];

    signed_extreme_tracker #(
        .WIDTH     (WIDTH),
        .N_SAMPLES (N_SAMPLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_mode  (out_mode)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stops a run that hangs, after printing a failure line.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model. It converts each sample to a signed integer and scans
    // for the extreme value. The earliest position wins a tie.
    function automatic void model(input logic [3:0][WIDTH-1:0] s, input logic m0,
                                  output int d, output int idx);
        int vals[4];
        for (int i = 0; i < 4; i++) vals[i] = int'($signed(s[i]));
        d   = vals[0];
        idx = 0;
        for (int i = 1; i < 4; i++) begin
            if (m0 ? (vals[i] < d) : (vals[i] > d)) begin
                d   = vals[i];
                idx = i;
            end
        end
    endfunction

    function automatic vec_t mk(input string name, input int a, input int b, input int c,
                                input int d, input logic [3:0] m, input int ed,
                                input int ei, input int em, input int hold);
        vec_t v;
        v.name       = name;
        v.samples[0] = 3'(a);
        v.samples[1] = 3'(b);
        v.samples[2] = 3'(c);
        v.samples[3] = 3'(d);
        v.modes      = m;
        v.exp_data   = ed;
        v.exp_idx    = ei;
        v.exp_mode   = em;
        v.hold       = hold;
        return v;
    endfunction

    // Offers the first n samples of a frame. Idle gaps of random length (up
    // to gap_max cycles) go before each sample. Every transfer waits a bounded
    // time for in_ready.
    task automatic apply_stimulus(input logic [3:0][WIDTH-1:0] s, input logic [3:0] m,
                                  input int n, input int gap_max);
        int g;
        int waited;
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                g        = int'($urandom_range(gap_max, 0));
                in_valid = 1'b0;
                repeat (g) begin
                    mode    = 1'($urandom);
                    in_data = 3'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = s[i];
            mode     = m[i];
            waited   = 0;
            @(negedge clk);
            while (!in_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL ready_timeout actual=%0d expected=1", in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Call this just after the edge that accepts the last sample. It checks
    // the result and its stability while out_ready stays low for hold cycles.
    // It then completes the result handshake.
    task automatic check_output(input string name, input int exp_d, input int exp_i,
                                input int exp_m, input int hold);
        @(negedge clk);
        check_val({name, "_out_valid"}, int'(out_valid), 1);
        check_val({name, "_in_ready_low"}, int'(in_ready), 0);
        check_val({name, "_data"}, int'($signed(out_data)), exp_d);
        check_val({name, "_index"}, int'(out_index), exp_i);
        check_val({name, "_mode"}, int'(out_mode), exp_m);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val({name, "_hold_valid"}, int'(out_valid), 1);
            check_val({name, "_hold_in_ready"}, int'(in_ready), 0);
            check_val({name, "_hold_data"}, int'($signed(out_data)), exp_d);
            check_val({name, "_hold_index"}, int'(out_index), exp_i);
            check_val({name, "_hold_mode"}, int'(out_mode), exp_m);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({name, "_released_valid"}, int'(out_valid), 0);
        check_val({name, "_released_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [3:0][WIDTH-1:0] rs;
        logic [3:0]            rm;
        int                    md;
        int                    mi;

        vectors[0] = mk("max_basic", 3, -4, 1, -1, 4'b0000, 3, 0, 0, 5);
        vectors[1] = mk("min_basic", 3, -4, 1, -1, 4'b1111, -4, 1, 1, 0);
        vectors[2] = mk("max_tie", -2, 2, 2, -3, 4'b0000, 2, 1, 0, 0);
        vectors[3] = mk("sign_boundary", -1, -4, -2, -3, 4'b0000, -1, 0, 0, 0);
        vectors[4] = mk("mode_toggle", 3, -4, 1, -1, 4'b1110, 3, 0, 0, 0);
        vectors[5] = mk("min_tie", 1, -3, -3, 2, 4'b1111, -3, 1, 1, 0);
        vectors[6] = mk("max_last", -4, -3, -2, 1, 4'b0000, 1, 3, 0, 0);

        rst_n     = 1'b0;
        clear     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #2;
        check_val("reset_out_valid", int'(out_valid), 0);
        check_val("reset_in_ready", int'(in_ready), 1);
        check_val("reset_out_data", int'(out_data), 0);
        check_val("reset_out_index", int'(out_index), 0);
        check_val("reset_out_mode", int'(out_mode), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            apply_stimulus(vectors[v].samples, vectors[v].modes, 4, 0);
            check_output(vectors[v].name, vectors[v].exp_data, vectors[v].exp_idx,
                         vectors[v].exp_mode, vectors[v].hold);
        end

        // A clear after two samples, with a would-be maximum offered
        // alongside it. The new frame must show only its own samples.
        rs = {3'(1), 3'(2), 3'(3), 3'(3)};
        apply_stimulus(rs, 4'b0000, 2, 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'(3);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check_val("clear_out_valid", int'(out_valid), 0);
        check_val("clear_in_ready", int'(in_ready), 1);
        rs = {3'(-4), 3'(-1), 3'(-3), 3'(-2)};
        apply_stimulus(rs, 4'b1111, 4, 0);
        check_output("after_clear", -4, 3, 1, 0);

        // A clear while a result is pending drops the result.
        rs = {3'(0), 3'(2), 3'(-1), 3'(1)};
        apply_stimulus(rs, 4'b0000, 4, 0);
        @(negedge clk);
        check_val("done_before_clear", int'(out_valid), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_val("clear_done_valid", int'(out_valid), 0);
        check_val("clear_done_in_ready", int'(in_ready), 1);
        rs = {3'(-2), 3'(-1), 3'(-3), 3'(-2)};
        apply_stimulus(rs, 4'b0000, 4, 0);
        check_output("after_clear_done", -1, 2, 0, 0);

        // A reset in the middle of a frame. The counter must restart at zero.
        rs = {3'(3), 3'(3), 3'(3), 3'(3)};
        apply_stimulus(rs, 4'b0000, 2, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rs = {3'(-4), 3'(-1), 3'(-3), 3'(-2)};
        apply_stimulus(rs, 4'b0000, 4, 0);
        check_output("after_rst_mid", -1, 2, 0, 0);

        // A reset while a result is pending. The reset is asynchronous, so
        // the outputs must clear before the next clock edge.
        rs = {3'(-1), 3'(0), 3'(1), 3'(2)};
        apply_stimulus(rs, 4'b1111, 4, 0);
        @(negedge clk);
        check_val("done_before_rst", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_done_valid", int'(out_valid), 0);
        check_val("rst_done_in_ready", int'(in_ready), 1);
        check_val("rst_done_data", int'(out_data), 0);
        check_val("rst_done_index", int'(out_index), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rs = {3'(0), 3'(-1), 3'(1), 3'(2)};
        apply_stimulus(rs, 4'b1111, 4, 0);
        check_output("after_rst_done", -1, 2, 1, 0);

        // Random frames with random idle gaps and random result hold times.
        // The mode for every sample is random, but only the first counts.
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 4; i++) rs[i] = 3'($urandom);
            rm = 4'($urandom);
            model(rs, rm[0], md, mi);
            apply_stimulus(rs, rm, 4, 2);
            check_output("random", md, mi, int'(rm[0]), int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
